rr_arb_param: RTL and testbench
===============================

// Module: rr_arb_param
// PURPOSE
//  N-way round-robin arbiter. Grants one requester at a time for a bounded tenure of HOLD cycles.
//  Early release occurs when the owner drops req. A one-cycle dead gap separates consecutive grants.
//  Sits in front of a shared resource (bus/memory port).
//  Successor of the fixed 4-way arbiter; generalised in channel count and tenure, and adds early release.
// PARAMETERS
//  N     4  number of requesters, legal 2..16
//  HOLD  8  max consecutive grant cycles per tenure, legal 1..256
//  localparam IDW = (N>1)?$clog2(N):1    width of gnt_id
//  localparam CW  = (HOLD>1)?$clog2(HOLD):1  tenure counter width
// PORTS
//  clk      in   1    clock, all state on posedge
//  resetl   in   1    reset, synchronous, active-low
//  req      in   N    request per channel, level, held until served
//  gnt      out  N    one-hot grant, all-zero when no owner
//  gnt_vld  out  1    =|gnt
//  gnt_id   out  IDW  index of current owner; holds last owner when gnt_vld=0
//  lock     in   N    only with ARB_LOCK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (resetl=0 at posedge): state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, cnt=0, ptr=N-1.
//    Reset overrides everything, including mid-tenure; the grant drops on the next edge.
//  - ptr = last owner. Priority search starts at ptr+1 mod N and wraps. After reset, ch0 is first.
//  - FSM states:
//    - IDLE: gnt=0.
//      - Any req set -> GRANT(winner), ptr<=winner, cnt<=0.
//      - Otherwise stay in IDLE.
//    - GRANT: gnt[ptr]=1, other requests ignored.
//      - Exits to GAP when cnt==HOLD-1 (full tenure) or req[ptr]==0 (early release).
//      - Otherwise cnt<=cnt+1.
//    - GAP: gnt=0 for exactly one cycle. Arbitrates combinationally on req.
//      - Winner -> GRANT(winner), cnt<=0.
//      - No req -> IDLE.
//      - If the previous owner is the only requester, it is re-granted.
//  - Outputs are decoded from registered state/ptr only; no combinational path req->gnt.
//  - Latency: req rises in cycle t while IDLE -> gnt high in cycle t+1.
//  - Full tenure: gnt high exactly HOLD cycles, then 1 gap cycle.
//  - Early release: owner req low sampled at edge e -> gnt low after e.
//    Tenure length = cycles until the drop, minimum 1.
//  - HOLD=1: every grant lasts one cycle, then a gap.
//  - Counter never wraps: it saturates at HOLD-1 and resets to 0 on every GRANT entry.
//  - Illegal state encodings recover to IDLE.
// CONFIGURATION
//  - `define ARB_LOCK_EN: adds the lock[N-1:0] input.
//    - In GRANT with lock[ptr]=1, the HOLD expiry is suppressed. cnt saturates at HOLD-1.
//    - The tenure ends only on lock[ptr]=0 with cnt==HOLD-1, or on req[ptr]=0.
//    - The early-release rule still applies while locked.
//  - Undefined: no lock port; every tenure is bounded by HOLD.
// TESTING  (N=4, HOLD=8 unless stated)
//  1. resetl=0 for 2 cycles, req=4'hF -> gnt=0, gnt_vld=0, gnt_id=0 throughout.
//  2. req=4'b0001 constant from t0 -> gnt=0001 in t1..t8, 0000 in t9, 0001 in t10..t17.
//  3. req=4'hF constant -> owners in order 0,1,2,3,0. Each tenure is 8 cycles, each gap 1 cycle.
//     gnt_id tracks the owner.
//  4. req=4'b0010 alone, dropped after 3 grant cycles -> gnt=0010 for 3 cycles, then gap, then IDLE.
//     gnt_id stays 1.
//  5. resetl=0 during 4th cycle of ch2 tenure, req=4'b1100 -> gnt=0 next edge.
//     After release, ch2 is granted first (ptr=N-1 -> 0, ch2 is first set).
//  6. ARB_LOCK_EN, req=4'b0011, lock=4'b0001 for 12 cycles -> gnt=0001 for 12 cycles
//     (not 8), then gap, then gnt=0010.
//  Also: N=2/HOLD=1 and N=16/HOLD=256 builds pass cases 2-3 with scaled values.
//  Also: assert $onehot0(gnt) every cycle.

Source files
------------

// File: rtl/rr_arb_param_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The lock vector only exists when ARB_LOCK_EN is defined.
interface rr_arb_param_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif

  // Requester side: drives requests (and locks), observes grants.
  modport master (
    output req,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  gnt_vld,
    input  gnt_id
  );

  // Arbiter side: observes requests (and locks), drives grants.
  modport slave (
    input  req,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output gnt_vld,
    output gnt_id
  );
endinterface

// File: rtl/rr_arb_param.sv
// N-way round-robin arbiter with a bounded tenure of HOLD cycles,
// early release when the owner drops req, and a one-cycle dead gap
// between consecutive grants. Grants are decoded from registered
// state only, so there is no combinational path from req to gnt.
// Optional feature: define ARB_LOCK_EN to add the lock input, which
// lets an owner extend its tenure past HOLD while lock[owner] is high.
module rr_arb_param #(
  parameter int N    = 4,
  parameter int HOLD = 8
) (
  input  logic          clk,
  input  logic          resetl,
  rr_arb_param_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(HOLD - 1);
  localparam logic [IDW-1:0] PTR_INIT = IDW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [IDW-1:0] id_q, id_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           expire;

  // Rotating priority search starting one past the last owner; k==N
  // lands on the last owner itself so a sole requester is re-granted.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Tenure expiry; a held lock suppresses it while the counter saturates.
  always_comb begin
`ifdef ARB_LOCK_EN
    expire = (cnt == CNT_MAX) && !bus.lock[ptr];
`else
    expire = (cnt == CNT_MAX);
`endif
  end

  // State, owner pointer, reported id and tenure counter registers.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      state <= IDLE;
      ptr   <= PTR_INIT;
      id_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      id_q  <= id_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: arbitrate in IDLE/GAP, count the tenure in GRANT.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    id_n    = id_q;
    cnt_n   = cnt;
    case (state)
      IDLE, GAP: begin
        if (found) begin
          state_n = GRANT;
          ptr_n   = win;
          id_n    = win;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[ptr] || expire) begin
          state_n = GAP;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // One-hot grant decoded from the registered state and owner pointer.
  always_comb begin
    bus.gnt = '0;
    if (state == GRANT) begin
      bus.gnt[ptr] = 1'b1;
    end
  end

  assign bus.gnt_vld = |bus.gnt;
  assign bus.gnt_id  = id_q;

endmodule

// File: tb/tb_rr_arb_param.sv
// Randomised scoreboard bench for rr_arb_param. The stimulus process
// drives inputs on the falling edge, steps a behavioural model of the
// arbitration rules and queues the expected outputs; the monitor pops
// and compares after every rising edge.
module tb_rr_arb_param;
  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int IDW  = (N > 1) ? $clog2(N) : 1;

  typedef struct {
    logic [N-1:0]   gnt;
    logic           vld;
    logic [IDW-1:0] id;
  } exp_t;

  logic clk;
  logic resetl;
  logic [N-1:0] curLock;

  rr_arb_param_if #(.N(N)) bus ();

  rr_arb_param #(.N(N), .HOLD(HOLD)) dut (
    .clk    (clk),
    .resetl (resetl),
    .bus    (bus.slave)
  );

  exp_t expQ[$];
  int   checks;
  int   errors;

  // Behavioural model: phase 0 idle, 1 owning, 2 dead gap.
  int mPhase;
  int mLast;
  int mId;
  int mTenure;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pickWinner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [N-1:0] r, input logic rl, input logic [N-1:0] lk);
    int   w;
    exp_t e;
    if (!rl) begin
      mPhase  = 0;
      mLast   = N - 1;
      mId     = 0;
      mTenure = 0;
    end else if (mPhase == 1) begin
      if (!r[mLast] || (mTenure >= HOLD && !lk[mLast])) mPhase = 2;
      else mTenure++;
    end else begin
      w = pickWinner(r, mLast);
      if (w >= 0) begin
        mPhase  = 1;
        mLast   = w;
        mId     = w;
        mTenure = 1;
      end else begin
        mPhase = 0;
      end
    end
    e.gnt = (mPhase == 1) ? N'(1) << mLast : '0;
    e.vld = (mPhase == 1);
    e.id  = IDW'(mId);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic rl, input logic [N-1:0] lk, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.req = r;
      resetl  = rl;
      curLock = lk;
`ifdef ARB_LOCK_EN
      bus.lock = lk;
`endif
      modelStep(r, rl, lk);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    checks++;
    if (!$onehot0(bus.gnt)) begin
      errors++;
      $display("[TB] FAIL onehot0 t=%0t gnt=%b expected at most one bit set", $time, bus.gnt);
    end
    checks++;
    if (bus.gnt !== e.gnt) begin
      errors++;
      $display("[TB] FAIL gnt t=%0t got=%b expected=%b", $time, bus.gnt, e.gnt);
    end
    checks++;
    if (bus.gnt_vld !== e.vld) begin
      errors++;
      $display("[TB] FAIL gnt_vld t=%0t got=%b expected=%b", $time, bus.gnt_vld, e.vld);
    end
    checks++;
    if (bus.gnt_id !== e.id) begin
      errors++;
      $display("[TB] FAIL gnt_id t=%0t got=%0d expected=%0d", $time, bus.gnt_id, e.id);
    end
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checkOutput();
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] lk;
    logic         rl;
    checks   = 0;
    errors   = 0;
    resetl   = 1'b0;
    bus.req  = '1;
    curLock  = '0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    $display("[TB] start N=%0d HOLD=%0d", N, HOLD);

    // Reset with every channel requesting: no grant may appear.
    applyStimulus(4'hF, 1'b0, 4'h0, 2);
    // Single requester: full tenures separated by one-cycle gaps.
    applyStimulus(4'b0001, 1'b1, 4'h0, 20);
    applyStimulus(4'b0000, 1'b1, 4'h0, 3);
    // All requesting: rotation 0,1,2,3,0.
    applyStimulus(4'hF, 1'b1, 4'h0, 45);
    applyStimulus(4'b0000, 1'b1, 4'h0, 3);
    // Early release of channel 1 after three grant cycles.
    applyStimulus(4'b0010, 1'b1, 4'h0, 3);
    applyStimulus(4'b0000, 1'b1, 4'h0, 4);
    // Reset in the middle of a channel 2 tenure.
    applyStimulus(4'b1100, 1'b0, 4'h0, 1);
    applyStimulus(4'b1100, 1'b1, 4'h0, 4);
    applyStimulus(4'b1100, 1'b0, 4'h0, 1);
    applyStimulus(4'b1100, 1'b1, 4'h0, 12);
`ifdef ARB_LOCK_EN
    // Locked owner keeps the grant beyond HOLD.
    applyStimulus(4'b0000, 1'b1, 4'h0, 3);
    applyStimulus(4'b1100, 1'b0, 4'h0, 1);
    applyStimulus(4'b0011, 1'b1, 4'b0001, 12);
    applyStimulus(4'b0011, 1'b1, 4'b0000, 6);
`endif

    // Randomised sticky requests with occasional drops and resets.
    r  = '0;
    lk = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if (r[b]) begin
          if ($urandom_range(0, 11) == 0) r[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r[b] = 1'b1;
        end
`ifdef ARB_LOCK_EN
        if ($urandom_range(0, 5) == 0) lk[b] = ~lk[b];
`endif
      end
      rl = ($urandom_range(0, 99) != 0);
      applyStimulus(r, rl, lk, 1);
    end

    applyStimulus(4'b0000, 1'b1, 4'h0, 2);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
